// File: rtl/mips_cpu_bus_stall_injector.sv
// mips_cpu_bus_stall_injector
//   Avalon-MM wait-state injector between the CPU bus master (s_*) and the RAM model (m_*).
//   Every CPU transfer is held off for 1 + cnt cycles before it reaches the RAM. cnt is the low
//   WAIT_BITS of a 16-bit Galois LFSR, sampled when the request is captured. Injected stall
//   cycles are counted in a saturating 32-bit counter.
//
// Parameters
//   WAIT_BITS  width of the per-transfer extra stall count (>= 1)
//   SEED       LFSR reset value; 0 is replaced by 16'hACE1
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   s_address/s_write/s_read/s_writedata/s_byteenable   CPU request
//   s_waitrequest/s_readdata    stall and read data back to the CPU
//   m_address/m_write/m_read/m_writedata/m_byteenable   request to RAM
//   m_waitrequest/m_readdata    stall and read data from RAM
//   stall_count                 total injected stall cycles, saturating
//   protocol_error              sticky master-protocol violation flag
//
// Build option
//   BUS_PROTOCOL_CHECK_EN: when defined, protocol_error flags a CPU that changes its request while
//   stalled, or that raises s_read and s_write together. Otherwise protocol_error is tied to 0.
module mips_cpu_bus_stall_injector #(
  parameter int unsigned WAIT_BITS = 2,
  parameter logic [15:0] SEED      = 16'h0003
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_address,
  input  logic        s_write,
  input  logic        s_read,
  output logic        s_waitrequest,
  input  logic [31:0] s_writedata,
  input  logic [3:0]  s_byteenable,
  output logic [31:0] s_readdata,
  output logic [31:0] m_address,
  output logic        m_write,
  output logic        m_read,
  input  logic        m_waitrequest,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic [31:0] m_readdata,
  output logic [31:0] stall_count,
  output logic        protocol_error
);

  localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  typedef enum logic [1:0] {StIdle, StStall, StFwd} state_e;

  state_e               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [WAIT_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]          stall_count_q, stall_count_d;
  logic                 stall_inc;
  logic                 req;

  assign req = s_read | s_write;

  // Data paths are pure pass-through; only the handshake is gated.
  assign m_address    = s_address;
  assign m_writedata  = s_writedata;
  assign m_byteenable = s_byteenable;
  assign s_readdata   = m_readdata;
  assign stall_count  = stall_count_q;

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    cnt_d         = cnt_q;
    m_read        = 1'b0;
    m_write       = 1'b0;
    s_waitrequest = 1'b0;
    stall_inc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The capture cycle itself is always a stall, so every transfer sees at least one.
        s_waitrequest = req;
        if (req) begin
          stall_inc = 1'b1;
          cnt_d     = lfsr_q[WAIT_BITS-1:0];
          lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
          state_d   = (lfsr_q[WAIT_BITS-1:0] == '0) ? StFwd : StStall;
        end
      end
      StStall: begin
        s_waitrequest = 1'b1;
        stall_inc     = 1'b1;
        cnt_d         = cnt_q - 1'b1;
        if (cnt_q == WAIT_BITS'(1)) state_d = StFwd;
      end
      StFwd: begin
        m_read        = s_read;
        m_write       = s_write;
        s_waitrequest = m_waitrequest;
        // Return to IDLE on completion, or if the CPU abandoned the request.
        if (!req || !m_waitrequest) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_inc && (stall_count_q != 32'hFFFF_FFFF)) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      lfsr_q        <= SeedEff;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

`ifdef BUS_PROTOCOL_CHECK_EN
  logic [31:0] prev_addr_q;
  logic [31:0] prev_wdata_q;
  logic [3:0]  prev_be_q;
  logic        prev_rd_q;
  logic        prev_wr_q;
  logic        prev_wait_q;
  logic        perr_q, perr_d;
  logic        req_changed;

  assign req_changed = (s_address != prev_addr_q) || (s_writedata != prev_wdata_q) ||
                       (s_byteenable != prev_be_q) || (s_read != prev_rd_q) ||
                       (s_write != prev_wr_q);

  always_comb begin
    perr_d = perr_q;
    if (((state_q == StStall) || (state_q == StFwd)) && prev_wait_q && req_changed) perr_d = 1'b1;
    if (s_read && s_write) perr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_addr_q  <= '0;
      prev_wdata_q <= '0;
      prev_be_q    <= '0;
      prev_rd_q    <= 1'b0;
      prev_wr_q    <= 1'b0;
      prev_wait_q  <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      prev_addr_q  <= s_address;
      prev_wdata_q <= s_writedata;
      prev_be_q    <= s_byteenable;
      prev_rd_q    <= s_read;
      prev_wr_q    <= s_write;
      prev_wait_q  <= s_waitrequest;
      perr_q       <= perr_d;
    end
  end

  assign protocol_error = perr_q;
`else
  assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_mips_cpu_bus_stall_injector.sv
// Bench for mips_cpu_bus_stall_injector: directed reset / stall-count cases followed by random
// reads and writes against a behavioural RAM and an expected-memory scoreboard.
module tb_mips_cpu_bus_stall_injector;

  localparam int unsigned WB   = 2;
  localparam logic [15:0] SEED = 16'h0003;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_address;
  logic        s_write;
  logic        s_read;
  logic        s_waitrequest;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic [31:0] s_readdata;
  logic [31:0] m_address;
  logic        m_write;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata;
  logic [31:0] stall_count;
  logic        protocol_error;

  mips_cpu_bus_stall_injector #(.WAIT_BITS(WB), .SEED(SEED)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_address      (s_address),
    .s_write        (s_write),
    .s_read         (s_read),
    .s_waitrequest  (s_waitrequest),
    .s_writedata    (s_writedata),
    .s_byteenable   (s_byteenable),
    .s_readdata     (s_readdata),
    .m_address      (m_address),
    .m_write        (m_write),
    .m_read         (m_read),
    .m_waitrequest  (m_waitrequest),
    .m_writedata    (m_writedata),
    .m_byteenable   (m_byteenable),
    .m_readdata     (m_readdata),
    .stall_count    (stall_count),
    .protocol_error (protocol_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // RAM model: holds each access off for ram_wait_cfg cycles.
  logic [31:0] ram [256];
  logic        mem_init;
  int          ram_wait_cfg;
  int          ram_waited;

  assign m_waitrequest = (m_read | m_write) && (ram_waited < ram_wait_cfg);
  assign m_readdata    = ram[m_address[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_waited <= 0;
    end else if (m_read | m_write) begin
      if (m_waitrequest) ram_waited <= ram_waited + 1;
      else begin
        ram_waited <= 0;
        if (m_write)
          for (int b = 0; b < 4; b++)
            if (m_byteenable[b]) ram[m_address[9:2]][8*b +: 8] <= m_writedata[8*b +: 8];
      end
    end
  end

  // Reference model state
  logic [31:0] exp_mem [256];
  logic [15:0] mdl_lfsr;
  int unsigned mdl_total;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one transfer starting in the low clock phase; returns in the low phase after it.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input int w, output int stalls);
    int  cnt;
    int  mcyc;
    bit  done;
    cnt      = int'(mdl_lfsr) % (1 << WB);
    mdl_lfsr = lfsr_step(mdl_lfsr);
    ram_wait_cfg = w;
    s_address    = addr;
    s_writedata  = data;
    s_byteenable = be;
    s_read       = !wr;
    s_write      = wr;
    stalls = 0;
    mcyc   = 0;
    done   = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      #1;
      if (m_read | m_write) mcyc++;
      if (!s_waitrequest) begin
        done = 1'b1;
        check("m_addr", m_address, addr);
        check("m_dir", {m_read, m_write}, {!wr, wr});
        if (wr) begin
          check("m_wdata", m_writedata, data);
          check("m_be", {28'd0, m_byteenable}, {28'd0, be});
          for (int b = 0; b < 4; b++)
            if (be[b]) exp_mem[addr[9:2]][8*b +: 8] = data[8*b +: 8];
        end else begin
          check("rdata", s_readdata, exp_mem[addr[9:2]]);
        end
      end else begin
        stalls++;
      end
      @(negedge clk);
    end
    check("done", {31'd0, done}, 32'd1);
    mdl_total += 32'(1 + cnt);
    check("stalls", stalls, 1 + cnt + w);
    check("ram_cycles", mcyc, w + 1);
    #1;
    check("stall_count", stall_count, mdl_total);
  endtask

  int          st;
  bit          wr;
  logic [31:0] addr;
  logic [3:0]  be;

  initial begin
    reset = 1'b1;
    mem_init = 1'b1;
    s_address = '0;
    s_writedata = '0;
    s_byteenable = '0;
    s_read = 1'b0;
    s_write = 1'b0;
    ram_wait_cfg = 0;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mem_init = 1'b0;
    mdl_lfsr = SEED;
    mdl_total = 0;
    #1;
    check("rst_wait", {31'd0, s_waitrequest}, 32'd0);
    check("rst_mrd", {31'd0, m_read | m_write}, 32'd0);
    check("rst_count", stall_count, 32'd0);
    check("rst_perr", {31'd0, protocol_error}, 32'd0);

    // Reset in the middle of an injected stall.
    s_address = 32'hBFC0_0000;
    s_byteenable = 4'hF;
    s_read = 1'b1;
    @(negedge clk); #1;
    check("mid_stall_wait", {31'd0, s_waitrequest}, 32'd1);
    check("mid_stall_mrd", {31'd0, m_read}, 32'd0);
    reset = 1'b1;
    s_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_mrd", {31'd0, m_read}, 32'd0);
    check("post_rst_count", stall_count, 32'd0);
    check("post_rst_wait", {31'd0, s_waitrequest}, 32'd0);
    mdl_lfsr = SEED;
    mdl_total = 0;

    // Two reads from the reset vector: 1+3 then 1+1 stalls.
    xfer(1'b0, 32'hBFC0_0000, 32'h0, 4'hF, 0, st);
    check("t1_stalls", st, 4);
    check("t1_count", stall_count, 32'd4);
    xfer(1'b0, 32'hBFC0_0004, 32'h0, 4'hF, 0, st);
    check("t2_stalls", st, 2);
    check("t2_count", stall_count, 32'd6);
    s_read = 1'b0;
    @(negedge clk); #1;

    // Random traffic with random RAM wait states and idle gaps.
    for (int t = 0; t < 60; t++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 32'hBFC0_0000 | (32'($urandom_range(0, 31)) << 2);
      be   = wr ? 4'($urandom_range(0, 15)) : 4'hF;
      xfer(wr, addr, $urandom, be, int'($urandom_range(0, 2)), st);
      if ($urandom_range(0, 2) != 0) begin
        s_read  = 1'b0;
        s_write = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        #1;
        check("idle_wait", {31'd0, s_waitrequest}, 32'd0);
        check("idle_mreq", {31'd0, m_read | m_write}, 32'd0);
      end
    end
    s_read  = 1'b0;
    s_write = 1'b0;
    @(negedge clk); #1;

`ifdef BUS_PROTOCOL_CHECK_EN
    check("perr_clean", {31'd0, protocol_error}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    s_address = 32'hBFC0_0010;
    s_read = 1'b1;
    @(negedge clk); #1;
    s_address = 32'hBFC0_0014;
    @(negedge clk); #1;
    check("perr_set", {31'd0, protocol_error}, 32'd1);
    s_read = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("perr_sticky", {31'd0, protocol_error}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("perr_cleared", {31'd0, protocol_error}, 32'd0);
`else
    check("perr_tied", {31'd0, protocol_error}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
